exu_wb_arbiter: RTL

EXU_WB_ARBITER -- requirements
Module: exu_wb_arbiter

---
 rtl/exu_wb_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/exu_wb_arbiter.sv
// Writeback arbiter: per-source FIFOs feeding one registered register-file write port.
// Fixed-priority or round-robin grant; writes to x0 are accepted and dropped.
module exu_wb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 2,
  parameter int RR_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_valid_i,
  output logic [NUM_SRC-1:0]        src_ready_o,
  input  logic [NUM_SRC*ADDR_W-1:0] src_waddr_i,
  input  logic [NUM_SRC*DATA_W-1:0] src_wdata_i,
  output logic                      reg_we_o,
  output logic [ADDR_W-1:0]         reg_waddr_o,
  output logic [DATA_W-1:0]         reg_wdata_o,
  output logic                      busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(NUM_SRC);
  localparam int EW = ADDR_W + DATA_W;

  logic [NUM_SRC-1:0]    full;
  logic [NUM_SRC-1:0]    empty;
  logic [NUM_SRC-1:0]    push;
  logic [NUM_SRC-1:0]    pop;
  logic [NUM_SRC*EW-1:0] heads;

  logic          gnt_vld;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] rr_ptr;
  logic [EW-1:0] head_sel;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    assign waddr    = src_waddr_i[i*ADDR_W +: ADDR_W];
    assign wdata    = src_wdata_i[i*DATA_W +: DATA_W];
    assign full[i]  = (cnt == CW'(DEPTH));
    assign empty[i] = (cnt == '0);
    // x0 writes complete the handshake but never occupy a slot
    assign push[i]  = src_valid_i[i] & ~full[i] & (waddr != '0);
    assign pop[i]   = gnt_vld & (gnt_idx == IW'(i));
    assign heads[i*EW +: EW] = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push[i]) wr_ptr <= wr_ptr + PW'(1);
        if (pop[i])  rd_ptr <= rd_ptr + PW'(1);
        unique case ({push[i], pop[i]})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (push[i]) mem[wr_ptr] <= {waddr, wdata};
    end
  end

  // Scan starts at rr_ptr in round-robin mode, at 0 in fixed mode
  always_comb begin
    logic [IW-1:0] base;
    logic [IW-1:0] idx;
    int j;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    j       = 0;
    base    = (RR_MODE != 0) ? rr_ptr : '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = int'(base) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      idx = IW'(j);
      if (!gnt_vld && !empty[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    head_sel = heads[int'(gnt_idx)*EW +: EW];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (gnt_vld) begin
      rr_ptr <= (gnt_idx == IW'(NUM_SRC-1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_we_o    <= 1'b0;
      reg_waddr_o <= '0;
      reg_wdata_o <= '0;
    end else begin
      reg_we_o <= gnt_vld;
      if (gnt_vld) {reg_waddr_o, reg_wdata_o} <= head_sel;
    end
  end

  assign src_ready_o = ~full;
  assign busy_o      = ~(&empty) | reg_we_o;

endmodule
